// File: rtl/store_drain_ctrl.sv
// Store drain controller: takes the non-speculative head of the store buffer
// and writes it either into the data cache or out on the IO bus. Only one
// store is outstanding at a time. IO stores can fail or time out; a failed
// store still retires, and its address is kept for the exception path.
module store_drain_ctrl #(
  parameter int PHYS       = 32,
  parameter int IO_TIMEOUT = 255
) (
  input  logic            cpu_clk_i,
  input  logic            cpu_rst_i,
  input  logic [PHYS-3:0] sb_address_i,
  input  logic [31:0]     sb_data_i,
  input  logic [3:0]      sb_bm_i,
  input  logic            sb_io_i,
  input  logic            sb_valid_i,
  input  logic            sb_no_nonspec_i,
  output logic            sb_done_o,
  output logic            dc_req_o,
  output logic [PHYS-3:0] dc_addr_o,
  output logic [31:0]     dc_data_o,
  output logic [3:0]      dc_bm_o,
  input  logic            dc_gnt_i,
  input  logic            dc_busy_i,
  output logic            io_req_o,
  output logic [PHYS-3:0] io_addr_o,
  output logic [31:0]     io_data_o,
  output logic [3:0]      io_bm_o,
  input  logic            io_gnt_i,
  input  logic            io_ack_i,
  input  logic            io_err_i,
  input  logic            fence_req_i,
  output logic            fence_done_o,
  output logic            store_err_o,
  output logic [PHYS-3:0] err_addr_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DC_WR   = 3'd1,
    IO_REQ  = 3'd2,
    IO_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] TimeoutLast = 8'(IO_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [PHYS-3:0] r_addr;
  logic [31:0]     r_data;
  logic [3:0]      r_bm;
  logic [7:0]      r_cnt;
  logic            r_err;
  logic [PHYS-3:0] r_errAddr;
  logic            w_ioFinish;
  logic            w_ioFail;

  // Next-state logic; also flags how an IO write finished (ack or timeout).
  always_comb begin
    w_next     = r_state;
    w_ioFinish = 1'b0;
    w_ioFail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sb_valid_i) w_next = sb_io_i ? IO_REQ : DC_WR;
      end
      DC_WR: begin
        if (!dc_busy_i && dc_gnt_i) w_next = DONE;
      end
      IO_REQ: begin
        if (io_gnt_i) w_next = IO_WAIT;
      end
      IO_WAIT: begin
        if (io_ack_i) begin
          w_ioFinish = 1'b1;
          w_ioFail   = io_err_i;
        end else if (r_cnt == TimeoutLast) begin
          w_ioFinish = 1'b1;
          w_ioFail   = 1'b1;
        end
        if (w_ioFinish) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight store without retiring it.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Holding registers capture the head only when IDLE accepts it.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      r_addr <= '0;
      r_data <= '0;
      r_bm   <= '0;
    end else if (r_state == IDLE && sb_valid_i) begin
      r_addr <= sb_address_i;
      r_data <= sb_data_i;
      r_bm   <= sb_bm_i;
    end
  end

  // IO timeout counter, error flag and the sticky failed-store address.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_errAddr <= '0;
    end else begin
      if (r_state == IO_REQ && io_gnt_i) r_cnt <= '0;
      else if (r_state == IO_WAIT && !io_ack_i) r_cnt <= r_cnt + 8'd1;
      if (w_ioFinish) r_err <= w_ioFail;
      else if (r_state == DONE) r_err <= 1'b0;
      if (w_ioFinish && w_ioFail) r_errAddr <= r_addr;
    end
  end

  assign dc_req_o     = (r_state == DC_WR) && !dc_busy_i;
  assign io_req_o     = (r_state == IO_REQ);
  assign sb_done_o    = (r_state == DONE);
  assign store_err_o  = (r_state == DONE) && r_err;
  assign err_addr_o   = r_errAddr;
  assign dc_addr_o    = r_addr;
  assign dc_data_o    = r_data;
  assign dc_bm_o      = r_bm;
  assign io_addr_o    = r_addr;
  assign io_data_o    = r_data;
  assign io_bm_o      = r_bm;
  assign fence_done_o = fence_req_i && (r_state == IDLE) && sb_no_nonspec_i && !sb_valid_i;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl. Inputs change on the falling edge and
// outputs are sampled 1ns later, so each "cycle" below is one clock period.
module tb_store_drain_ctrl;

  logic        cpu_clk_i;
  logic        cpu_rst_i;
  logic [29:0] sb_address_i;
  logic [31:0] sb_data_i;
  logic [3:0]  sb_bm_i;
  logic        sb_io_i, sb_valid_i, sb_no_nonspec_i, sb_done_o;
  logic        dc_req_o;
  logic [29:0] dc_addr_o;
  logic [31:0] dc_data_o;
  logic [3:0]  dc_bm_o;
  logic        dc_gnt_i, dc_busy_i, io_req_o;
  logic [29:0] io_addr_o;
  logic [31:0] io_data_o;
  logic [3:0]  io_bm_o;
  logic        io_gnt_i, io_ack_i, io_err_i, fence_req_i, fence_done_o, store_err_o;
  logic [29:0] err_addr_o;

  int checks   = 0;
  int failures = 0;

  store_drain_ctrl #(.PHYS(32), .IO_TIMEOUT(4)) dut (
    .cpu_clk_i(cpu_clk_i), .cpu_rst_i(cpu_rst_i),
    .sb_address_i(sb_address_i), .sb_data_i(sb_data_i), .sb_bm_i(sb_bm_i),
    .sb_io_i(sb_io_i), .sb_valid_i(sb_valid_i), .sb_no_nonspec_i(sb_no_nonspec_i),
    .sb_done_o(sb_done_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_bm_o(dc_bm_o),
    .dc_gnt_i(dc_gnt_i), .dc_busy_i(dc_busy_i),
    .io_req_o(io_req_o), .io_addr_o(io_addr_o), .io_data_o(io_data_o), .io_bm_o(io_bm_o),
    .io_gnt_i(io_gnt_i), .io_ack_i(io_ack_i), .io_err_i(io_err_i),
    .fence_req_i(fence_req_i), .fence_done_o(fence_done_o),
    .store_err_o(store_err_o), .err_addr_o(err_addr_o)
  );

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  // Advance to the next falling edge and return every input to its quiet value.
  task automatic tick();
    @(negedge cpu_clk_i);
    cpu_rst_i = 0; sb_address_i = '0; sb_data_i = '0; sb_bm_i = '0; sb_io_i = 0;
    sb_valid_i = 0; sb_no_nonspec_i = 0; dc_gnt_i = 0; dc_busy_i = 0;
    io_gnt_i = 0; io_ack_i = 0; io_err_i = 0; fence_req_i = 0;
  endtask

  task automatic test_reset();
    cpu_rst_i = 1; sb_address_i = '0; sb_data_i = '0; sb_bm_i = '0; sb_io_i = 0;
    sb_valid_i = 0; sb_no_nonspec_i = 0; dc_gnt_i = 0; dc_busy_i = 0;
    io_gnt_i = 0; io_ack_i = 0; io_err_i = 0; fence_req_i = 0;
    @(negedge cpu_clk_i); @(negedge cpu_clk_i);
    tick(); #1;
    checks++; if (sb_done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b exp=0", sb_done_o); end
    checks++; if (dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_dcreq got=%0b exp=0", dc_req_o); end
    checks++; if (io_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ioreq got=%0b exp=0", io_req_o); end
    checks++; if (store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", store_err_o); end
    checks++; if (err_addr_o !== 30'h0) begin failures++; $display("[TB] FAIL reset_erraddr got=%h exp=0", err_addr_o); end
    checks++; if (fence_done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fence got=%0b exp=0", fence_done_o); end
    tick(); fence_req_i = 1; sb_no_nonspec_i = 1; #1;
    checks++; if (fence_done_o !== 1'b1) begin failures++; $display("[TB] FAIL idle_fence got=%0b exp=1", fence_done_o); end
  endtask

  task automatic test_cacheable();
    tick(); sb_valid_i = 1; sb_address_i = 30'h100; sb_data_i = 32'hDEADBEEF; sb_bm_i = 4'hF; dc_gnt_i = 1; #1;
    checks++; if (dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL cache_idle_req got=%0b exp=0", dc_req_o); end
    tick(); dc_gnt_i = 1; #1;
    checks++; if (dc_req_o !== 1'b1) begin failures++; $display("[TB] FAIL cache_req got=%0b exp=1", dc_req_o); end
    checks++; if (dc_addr_o !== 30'h100) begin failures++; $display("[TB] FAIL cache_addr got=%h exp=100", dc_addr_o); end
    checks++; if (dc_data_o !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL cache_data got=%h exp=deadbeef", dc_data_o); end
    checks++; if (dc_bm_o !== 4'hF) begin failures++; $display("[TB] FAIL cache_bm got=%h exp=f", dc_bm_o); end
    checks++; if (io_req_o !== 1'b0) begin failures++; $display("[TB] FAIL cache_ioreq got=%0b exp=0", io_req_o); end
    checks++; if (sb_done_o !== 1'b0) begin failures++; $display("[TB] FAIL cache_early_done got=%0b exp=0", sb_done_o); end
    tick(); #1;
    checks++; if (sb_done_o !== 1'b1) begin failures++; $display("[TB] FAIL cache_done got=%0b exp=1", sb_done_o); end
    checks++; if (store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL cache_err got=%0b exp=0", store_err_o); end
    checks++; if (dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL cache_done_req got=%0b exp=0", dc_req_o); end
  endtask

  task automatic test_refill();
    int dones = 0;
    tick(); sb_valid_i = 1; sb_address_i = 30'h204; sb_data_i = 32'h12345678; sb_bm_i = 4'h5; dc_busy_i = 1; dc_gnt_i = 1; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); dc_busy_i = 1; dc_gnt_i = 1; #1;
      checks++; if (dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL refill_req_busy%0d got=%0b exp=0", i, dc_req_o); end
      dones += int'(sb_done_o);
    end
    tick(); dc_gnt_i = 1; #1;
    checks++; if (dc_req_o !== 1'b1) begin failures++; $display("[TB] FAIL refill_req got=%0b exp=1", dc_req_o); end
    checks++; if (dc_addr_o !== 30'h204) begin failures++; $display("[TB] FAIL refill_addr got=%h exp=204", dc_addr_o); end
    dones += int'(sb_done_o);
    for (int i = 0; i < 3; i++) begin
      tick(); #1; dones += int'(sb_done_o);
    end
    checks++; if (dones !== 1) begin failures++; $display("[TB] FAIL refill_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_io();
    int dones = 0;
    tick(); sb_valid_i = 1; sb_io_i = 1; sb_address_i = 30'h3ABC; sb_data_i = 32'hCAFE0001; sb_bm_i = 4'h3; #1;
    tick(); io_ack_i = 1; #1;
    checks++; if (io_req_o !== 1'b1) begin failures++; $display("[TB] FAIL io_req got=%0b exp=1", io_req_o); end
    checks++; if (io_addr_o !== 30'h3ABC) begin failures++; $display("[TB] FAIL io_addr got=%h exp=3abc", io_addr_o); end
    checks++; if (io_data_o !== 32'hCAFE0001) begin failures++; $display("[TB] FAIL io_data got=%h exp=cafe0001", io_data_o); end
    checks++; if (io_bm_o !== 4'h3) begin failures++; $display("[TB] FAIL io_bm got=%h exp=3", io_bm_o); end
    checks++; if (dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL io_dcreq got=%0b exp=0", dc_req_o); end
    tick(); #1;
    checks++; if (io_req_o !== 1'b1) begin failures++; $display("[TB] FAIL io_req_hold got=%0b exp=1", io_req_o); end
    tick(); io_gnt_i = 1; #1;
    tick(); #1;
    checks++; if (io_req_o !== 1'b0) begin failures++; $display("[TB] FAIL io_wait_req got=%0b exp=0", io_req_o); end
    dones += int'(sb_done_o);
    tick(); #1; dones += int'(sb_done_o);
    tick(); io_ack_i = 1; io_err_i = 1; #1; dones += int'(sb_done_o);
    tick(); #1; dones += int'(sb_done_o);
    checks++; if (sb_done_o !== 1'b1) begin failures++; $display("[TB] FAIL io_done got=%0b exp=1", sb_done_o); end
    checks++; if (store_err_o !== 1'b1) begin failures++; $display("[TB] FAIL io_err got=%0b exp=1", store_err_o); end
    checks++; if (err_addr_o !== 30'h3ABC) begin failures++; $display("[TB] FAIL io_erraddr got=%h exp=3abc", err_addr_o); end
    tick(); #1; dones += int'(sb_done_o);
    checks++; if (store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL io_err_pulse got=%0b exp=0", store_err_o); end
    checks++; if (dones !== 1) begin failures++; $display("[TB] FAIL io_done_count got=%0d exp=1", dones); end
    // A successful IO write must not raise an error or disturb err_addr_o.
    tick(); sb_valid_i = 1; sb_io_i = 1; sb_address_i = 30'h55; #1;
    tick(); io_gnt_i = 1; #1;
    tick(); io_ack_i = 1; #1;
    tick(); #1;
    checks++; if (sb_done_o !== 1'b1) begin failures++; $display("[TB] FAIL iook_done got=%0b exp=1", sb_done_o); end
    checks++; if (store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL iook_err got=%0b exp=0", store_err_o); end
    checks++; if (err_addr_o !== 30'h3ABC) begin failures++; $display("[TB] FAIL iook_erraddr got=%h exp=3abc", err_addr_o); end
  endtask

  task automatic test_timeout();
    tick(); sb_valid_i = 1; sb_io_i = 1; sb_address_i = 30'h777; #1;
    tick(); io_gnt_i = 1; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++; if (sb_done_o !== 1'b0) begin failures++; $display("[TB] FAIL tmo_wait%0d_done got=%0b exp=0", i, sb_done_o); end
    end
    tick(); #1;
    checks++; if (sb_done_o !== 1'b1) begin failures++; $display("[TB] FAIL tmo_done got=%0b exp=1", sb_done_o); end
    checks++; if (store_err_o !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err got=%0b exp=1", store_err_o); end
    checks++; if (err_addr_o !== 30'h777) begin failures++; $display("[TB] FAIL tmo_erraddr got=%h exp=777", err_addr_o); end
    tick(); io_ack_i = 1; io_err_i = 1; #1;
    checks++; if (sb_done_o !== 1'b0 || store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL tmo_stale got=%0b%0b exp=00", sb_done_o, store_err_o); end
    tick(); #1;
    checks++; if (sb_done_o !== 1'b0 || io_req_o !== 1'b0) begin failures++; $display("[TB] FAIL tmo_after got=%0b%0b exp=00", sb_done_o, io_req_o); end
  endtask

  task automatic test_back_to_back_fence();
    int dones = 0;
    tick(); fence_req_i = 1; sb_valid_i = 1; sb_address_i = 30'hA0; dc_gnt_i = 1; #1;
    checks++; if (fence_done_o !== 1'b0) begin failures++; $display("[TB] FAIL fence_c0 got=%0b exp=0", fence_done_o); end
    tick(); fence_req_i = 1; sb_valid_i = 1; sb_address_i = 30'hA0; dc_gnt_i = 1; #1;
    checks++; if (dc_addr_o !== 30'hA0) begin failures++; $display("[TB] FAIL b2b_addr0 got=%h exp=a0", dc_addr_o); end
    tick(); fence_req_i = 1; sb_valid_i = 1; sb_address_i = 30'hA0; dc_gnt_i = 1; #1;
    dones += int'(sb_done_o);
    checks++; if (fence_done_o !== 1'b0) begin failures++; $display("[TB] FAIL fence_c2 got=%0b exp=0", fence_done_o); end
    tick(); fence_req_i = 1; sb_valid_i = 1; sb_address_i = 30'hB4; dc_gnt_i = 1; #1;
    checks++; if (sb_done_o !== 1'b0 || dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%0b%0b exp=00", sb_done_o, dc_req_o); end
    tick(); fence_req_i = 1; dc_gnt_i = 1; #1;
    checks++; if (dc_req_o !== 1'b1 || dc_addr_o !== 30'hB4) begin failures++; $display("[TB] FAIL b2b_req1 got=%0b/%h exp=1/b4", dc_req_o, dc_addr_o); end
    tick(); fence_req_i = 1; sb_no_nonspec_i = 1; #1;
    dones += int'(sb_done_o);
    checks++; if (fence_done_o !== 1'b0) begin failures++; $display("[TB] FAIL fence_in_done got=%0b exp=0", fence_done_o); end
    checks++; if (dones !== 2) begin failures++; $display("[TB] FAIL fence_done_count got=%0d exp=2", dones); end
    tick(); fence_req_i = 1; sb_no_nonspec_i = 1; #1;
    checks++; if (fence_done_o !== 1'b1) begin failures++; $display("[TB] FAIL fence_final got=%0b exp=1", fence_done_o); end
  endtask

  task automatic test_reset_mid();
    tick(); sb_valid_i = 1; sb_io_i = 1; sb_address_i = 30'h999; #1;
    tick(); io_gnt_i = 1; #1;
    tick(); cpu_rst_i = 1; #1;
    tick(); io_ack_i = 1; io_err_i = 1; #1;
    checks++; if (sb_done_o !== 1'b0 || store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%0b%0b exp=00", sb_done_o, store_err_o); end
    checks++; if (io_req_o !== 1'b0 || dc_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_req got=%0b%0b exp=00", io_req_o, dc_req_o); end
    checks++; if (err_addr_o !== 30'h0) begin failures++; $display("[TB] FAIL rstmid_erraddr got=%h exp=0", err_addr_o); end
    tick(); #1;
    checks++; if (sb_done_o !== 1'b0 || store_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_late got=%0b%0b exp=00", sb_done_o, store_err_o); end
  endtask

  initial begin
    test_reset();
    test_cacheable();
    test_refill();
    test_io();
    test_timeout();
    test_back_to_back_fence();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_drain_ctrl.md
STORE_DRAIN_CTRL -- requirements
Module: store_drain_ctrl

Interface
REQ-001 Parameter PHYS, default 32, physical address width; word addresses are PHYS-2 bits.
REQ-002 Parameter IO_TIMEOUT, default 255, maximum IO_WAIT cycles before abort; range 1..255.
REQ-003 cpu_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 cpu_rst_i  in  1  reset, synchronous, active-high.
REQ-005 sb_address_i  in  PHYS-2  store-buffer head word address.
REQ-006 sb_data_i  in  32  head data.
REQ-007 sb_bm_i  in  4  head byte mask.
REQ-008 sb_io_i  in  1  head is an IO (uncacheable) store.
REQ-009 sb_valid_i  in  1  head is non-speculative and drainable.
REQ-010 sb_no_nonspec_i  in  1  store buffer holds no non-speculative entries.
REQ-011 sb_done_o  out  1  one-cycle pulse; retires the store-buffer head; drives the buffer's cache_done.
REQ-012 dc_req_o / dc_addr_o / dc_data_o / dc_bm_o  out  1/PHYS-2/32/4  data-cache write request and payload.
REQ-013 dc_gnt_i  in  1  cache accepts the write in this cycle.
REQ-014 dc_busy_i  in  1  refill owns the cache write port; dc_req_o is forced low while high.
REQ-015 io_req_o / io_addr_o / io_data_o / io_bm_o  out  1/PHYS-2/32/4  IO bus write request and payload.
REQ-016 io_gnt_i  in  1  bus accepts the request.
REQ-017 io_ack_i / io_err_i  in  1/1  write response; io_err_i is valid only with io_ack_i.
REQ-018 fence_req_i  in  1  level; requester waits for store drain.
REQ-019 fence_done_o  out  1  drain complete; combinational level.
REQ-020 store_err_o  out  1  one-cycle pulse; IO store failed or timed out.
REQ-021 err_addr_o  out  PHYS-2  address of the last failed store; holds until the next error.

Function
REQ-022 FSM states: IDLE, DC_WR, IO_REQ, IO_WAIT, DONE.
REQ-023 IDLE with sb_valid_i: latch address, data, bm and io into holding registers; go to IO_REQ if io, else DC_WR.
- Payload outputs are always driven from the holding registers, never from sb_* inputs.
REQ-024 DC_WR: dc_req_o = !dc_busy_i.
- dc_req_o & dc_gnt_i -> DONE.
- Otherwise stay; dc_gnt_i while dc_busy_i is ignored.
REQ-025 IO_REQ: io_req_o = 1; io_gnt_i -> IO_WAIT with timeout counter cleared to 0.
- io_ack_i in IO_REQ is ignored.
REQ-026 IO_WAIT: the 8-bit counter increments each cycle without io_ack_i.
- io_ack_i -> DONE; error flag = io_err_i.
- Counter reaching IO_TIMEOUT without ack -> DONE; error flag = 1.
REQ-027 DONE: sb_done_o = 1 for exactly one cycle, then IDLE.
- If the error flag is set: store_err_o = 1 in the same cycle and err_addr_o loads the held address.
- A failed store still retires; it is not retried.
REQ-028 Cacheable latency with immediate grant: sb_valid_i seen in cycle N, dc_req_o in N+1, sb_done_o in N+2.
- Back-to-back stores drain at one per 3 cycles; IDLE never samples the retiring entry.
REQ-029 At most one of dc_req_o and io_req_o is high in any cycle; at most one store is outstanding.
REQ-030 fence_done_o = fence_req_i & state==IDLE & sb_no_nonspec_i & !sb_valid_i.
REQ-031 Pipeline flush does not affect this block; drained entries are already non-speculative.

Reset
REQ-032 cpu_rst_i high: next state IDLE.
- Counter, error flag and err_addr_o cleared to 0.
- All request, done, error and fence outputs 0 in the cycle after the reset edge.
REQ-033 Reset mid-operation abandons the in-flight store with no sb_done_o pulse.
- A late io_ack_i after reset is ignored.

Verification
REQ-034 Cacheable: sb_valid_i=1, io=0, addr=0x100, bm=0xF, dc_gnt_i=1 -> dc_req_o=1 with addr 0x100 one cycle later; sb_done_o pulse the cycle after; store_err_o=0.
REQ-035 Refill contention: dc_busy_i=1 for 4 cycles in DC_WR -> dc_req_o=0 for those 4 cycles; write issues in the 5th; exactly one sb_done_o pulse.
REQ-036 IO: io=1, io_gnt_i delayed 2 cycles, io_ack_i 3 cycles after grant with io_err_i=1 -> single sb_done_o; store_err_o=1; err_addr_o=held address.
REQ-037 Timeout with IO_TIMEOUT=4 and no io_ack_i -> DONE after 4 IO_WAIT cycles; store_err_o=1; subsequent stale io_ack_i in IDLE ignored.
REQ-038 Fence: fence_req_i=1 with 2 queued stores -> fence_done_o=0 until both sb_done_o pulses are seen and sb_no_nonspec_i=1, then 1.
REQ-039 Reset asserted in IO_WAIT -> IDLE next cycle; no sb_done_o or store_err_o; outputs 0.
